// File: rtl/pled_pkg.sv
// pled_pkg: shared types and width helpers for the power-LED PWM driver.
//   mode_t      global output mode (OFF / STATIC / BREATHE / BLINK)
//   clog2_min1  counter width helper that never returns 0
package pled_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_t;

  // Width needed to hold 0..v-1; at least one bit so v=1 still yields a legal vector.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? int'($clog2(v)) : 1;
  endfunction

endpackage

// File: rtl/pled_tick_gen.sv
// pled_tick_gen: PWM tick prescaler. Counts 0..CLK_DIV-1 while enabled and
// pulses tick_c for one cycle at the CLK_DIV-1 count.
//   clk     system clock
//   rst     synchronous reset, active-high
//   en      run enable; low clears the prescaler
//   tick_c  combinational one-cycle tick pulse
module pled_tick_gen
  import pled_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2700
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned         PSC_W    = clog2_min1(CLK_DIV);
  localparam logic [PSC_W-1:0]    PSC_LAST = PSC_W'(CLK_DIV - 1);

  logic [PSC_W-1:0] psc_q, psc_d;

  // Next prescaler count: wraps at CLK_DIV-1, held at 0 while disabled.
  always_comb begin
    psc_d = psc_q;
    if (!en) begin
      psc_d = '0;
    end else if (psc_q == PSC_LAST) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

  assign tick_c = en && (psc_q == PSC_LAST);

endmodule

// File: rtl/pled_pwm_multi.sv
// pled_pwm_multi: N-channel PWM driver for the power-LED Pmod with global
// OFF / STATIC / BREATHE / BLINK modes, prescaled tick and per-period shadowed
// duty/mode so input changes never glitch a running period.
//   clk           system clock
//   rst           synchronous reset, active-high
//   en            run enable; low clears and restarts the engine
//   mode          00 OFF, 01 STATIC, 10 BREATHE, 11 BLINK
//   duty          channel c duty at [c*PWM_W +: PWM_W]
//   pwm_out       registered PWM outputs, active-high
//   period_start  one-cycle pulse in the cycle the counter becomes 0
//   breath_level  current triangle breath envelope level
// Build option: PLED_GAMMA_EN applies a square-law gamma to the effective duty.
module pled_pwm_multi
  import pled_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2700,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned N_CH     = 3,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [N_CH*PWM_W-1:0]   duty,
  output logic [N_CH-1:0]         pwm_out,
  output logic                    period_start,
  output logic [PWM_W-1:0]        breath_level
);

  localparam int unsigned        PROD_W    = 2 * PWM_W;
  localparam int unsigned        STEP_W    = clog2_min1(STEP_DIV);
  localparam logic [PWM_W-1:0]   LVL_MAX   = '1;
  localparam logic [PWM_W-1:0]   CNT_LAST  = LVL_MAX - PWM_W'(1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic                    tick_c;
  logic [PWM_W-1:0]        cnt_q, cnt_d;
  logic [PWM_W-1:0]        lvl_q, lvl_d;
  logic                    dir_dn_q, dir_dn_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic                    started_q, started_d;
  mode_t                   mode_sh_q, mode_sh_d;
  logic [N_CH*PWM_W-1:0]   duty_sh_q, duty_sh_d;
  logic [N_CH-1:0]         pwm_out_q, pwm_out_d;
  logic                    period_start_q, period_start_d;

  pled_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .tick_c (tick_c)
  );

  // Period counter, breath envelope and shadow capture.
  always_comb begin
    cnt_d          = cnt_q;
    lvl_d          = lvl_q;
    dir_dn_d       = dir_dn_q;
    step_d         = step_q;
    started_d      = started_q;
    mode_sh_d      = mode_sh_q;
    duty_sh_d      = duty_sh_q;
    period_start_d = 1'b0;
    if (!en) begin
      cnt_d     = '0;
      lvl_d     = '0;
      dir_dn_d  = 1'b0;
      step_d    = '0;
      started_d = 1'b0;
      mode_sh_d = MODE_OFF;
      duty_sh_d = '0;
    end else if (tick_c) begin
      started_d = 1'b1;
      if (cnt_q == CNT_LAST) begin
        cnt_d          = '0;
        period_start_d = 1'b1;
        if (step_q == STEP_LAST) begin
          step_d = '0;
          // Triangle: each endpoint is visited once, direction flips on arrival.
          if (!dir_dn_q) begin
            lvl_d = lvl_q + PWM_W'(1);
            if (lvl_d == LVL_MAX) dir_dn_d = 1'b1;
          end else begin
            lvl_d = lvl_q - PWM_W'(1);
            if (lvl_d == '0) dir_dn_d = 1'b0;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end else begin
        cnt_d = cnt_q + PWM_W'(1);
      end
      // The first tick after a (re)start also loads, so the opening period is live.
      if (period_start_d || !started_q) begin
        mode_sh_d = mode_t'(mode);
        duty_sh_d = duty;
      end
    end
  end

  // Per-channel effective duty, evaluated on next-state values so pwm_out
  // moves on the same edge as the counter.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [PWM_W-1:0] duty_ch;
    logic [PWM_W-1:0] lin_c;
    logic [PWM_W-1:0] eff_c;

    assign duty_ch = duty_sh_d[c*PWM_W +: PWM_W];

    always_comb begin
      lin_c = '0;
      case (mode_sh_d)
        MODE_OFF:     lin_c = '0;
        MODE_STATIC:  lin_c = duty_ch;
        MODE_BREATHE: lin_c = PWM_W'((PROD_W'(duty_ch) * PROD_W'(lvl_d)) >> PWM_W);
        MODE_BLINK:   lin_c = dir_dn_d ? '0 : duty_ch;
        default:      lin_c = '0;
      endcase
    end

`ifdef PLED_GAMMA_EN
    // Full scale stays full on; otherwise square law.
    assign eff_c = (lin_c == LVL_MAX) ? LVL_MAX
                                      : PWM_W'((PROD_W'(lin_c) * PROD_W'(lin_c)) >> PWM_W);
`else
    assign eff_c = lin_c;
`endif

    assign pwm_out_d[c] = (cnt_d < eff_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      lvl_q          <= '0;
      dir_dn_q       <= 1'b0;
      step_q         <= '0;
      started_q      <= 1'b0;
      mode_sh_q      <= MODE_OFF;
      duty_sh_q      <= '0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      lvl_q          <= lvl_d;
      dir_dn_q       <= dir_dn_d;
      step_q         <= step_d;
      started_q      <= started_d;
      mode_sh_q      <= mode_sh_d;
      duty_sh_q      <= duty_sh_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign breath_level = lvl_q;

endmodule

// File: tb/tb_pled_pwm_multi.sv
// tb_pled_pwm_multi: self-checking bench for pled_pwm_multi at CLK_DIV=4,
// PWM_W=4, N_CH=3, STEP_DIV=1 (period 15 ticks = 60 clk). A per-cycle
// scoreboard predicts outputs from tick/period arithmetic; directed vectors
// and sequences measure whole periods.
module tb_pled_pwm_multi;

  localparam int CLK_DIV  = 4;
  localparam int PW       = 4;
  localparam int N_CH     = 3;
  localparam int STEP_DIV = 1;
  localparam int MAXV     = (1 << PW) - 1;
  localparam int PER      = MAXV;
  localparam int PER_CLK  = PER * CLK_DIV;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [1:0]           mode;
  logic [N_CH*PW-1:0]   duty;
  logic [N_CH-1:0]      pwm_out;
  logic                 period_start;
  logic [PW-1:0]        breath_level;

  int checks   = 0;
  int failures = 0;

  pled_pwm_multi #(
    .CLK_DIV  (CLK_DIV),
    .PWM_W    (PW),
    .N_CH     (N_CH),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .breath_level (breath_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int gam(input int lin);
`ifdef PLED_GAMMA_EN
    return (lin == MAXV) ? MAXV : (lin * lin) >> PW;
`else
    return lin;
`endif
  endfunction

  // Triangle envelope value after p level steps.
  function automatic int tri_level(input int p);
    int m;
    m = p % (2 * MAXV);
    return (m <= MAXV) ? m : 2 * MAXV - m;
  endfunction

  function automatic int eff_of(input int m, input int d, input int lvl, input bit up);
    int lin;
    case (m)
      1:       lin = d;
      2:       lin = (d * lvl) >> PW;
      3:       lin = up ? d : 0;
      default: lin = 0;
    endcase
    return gam(lin);
  endfunction

  // ---------------- reference model: state = enabled cycles and ticks since start
  int  s_cyc, k_tick, sh_mode;
  int  sh_duty [N_CH];
  int  exp_pwm, exp_lvl;
  bit  exp_ps;
  bit  mdl_ok = 1'b0;

  always @(posedge clk) begin
    int p;
    bit up;
    exp_ps = 1'b0;
    if (rst || !en) begin
      s_cyc   = 0;
      k_tick  = 0;
      sh_mode = 0;
      for (int c = 0; c < N_CH; c++) sh_duty[c] = 0;
    end else begin
      if (s_cyc % CLK_DIV == CLK_DIV - 1) begin
        k_tick++;
        if (k_tick % PER == 0) exp_ps = 1'b1;
        if (k_tick == 1 || k_tick % PER == 0) begin
          sh_mode = int'(mode);
          for (int c = 0; c < N_CH; c++) sh_duty[c] = int'(duty[c*PW +: PW]);
        end
      end
      s_cyc++;
    end
    p       = (k_tick / PER) / STEP_DIV;
    exp_lvl = tri_level(p);
    up      = (p % (2 * MAXV)) < MAXV;
    exp_pwm = 0;
    for (int c = 0; c < N_CH; c++)
      if ((k_tick % PER) < eff_of(sh_mode, sh_duty[c], exp_lvl, up)) exp_pwm |= (1 << c);
    mdl_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      check("sb_pwm_out", int'(pwm_out), exp_pwm);
      check("sb_period_start", int'(period_start), int'(exp_ps));
      check("sb_breath_level", int'(breath_level), exp_lvl);
    end
  end

  // ---------------- stimulus helpers
  task automatic set_in(input int m, input int d0, input int d1, input int d2);
    mode = 2'(m);
    duty = {PW'(d2), PW'(d1), PW'(d0)};
  endtask

  task automatic wait_ps();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("period_start_seen", int'(ok), 1);
  endtask

  // Count enabled negedges until period_start (bounded).
  task automatic count_to_ps(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (period_start) break;
    end
  endtask

  // High cycles per channel over one period starting at the current negedge.
  task automatic measure(input int mid, input int new_d1, output int h0, output int h1, output int h2);
    h0 = 0; h1 = 0; h2 = 0;
    for (int i = 0; i < PER_CLK; i++) begin
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
      if (i == mid) duty[PW +: PW] = PW'(new_d1);
      if (i < PER_CLK - 1) @(negedge clk);
    end
  endtask

  typedef struct {
    int m;
    int d0, d1, d2;
    int e0, e1, e2;
    int g0, g1, g2;
  } vec_t;

  vec_t vt [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, h2, n, x0, x1, x2;

    vt[0] = '{1, 0, 5, 15,  0, 5, 15,  0, 1, 15};
    vt[1] = '{1, 3, 8, 14,  3, 8, 14,  0, 4, 12};
    vt[2] = '{0, 7, 7, 7,   0, 0, 0,   0, 0, 0};
    vt[3] = '{1, 15, 1, 9,  15, 1, 9,  15, 0, 5};

    rst = 1'b1; en = 1'b0; mode = 2'b00; duty = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_period_start", int'(period_start), 0);
    check("reset_breath_level", int'(breath_level), 0);
    rst = 1'b0; en = 1'b1;

    // Table of static settings: high cycles per full period.
    for (int i = 0; i < 4; i++) begin
      set_in(vt[i].m, vt[i].d0, vt[i].d1, vt[i].d2);
`ifdef PLED_GAMMA_EN
      x0 = vt[i].g0; x1 = vt[i].g1; x2 = vt[i].g2;
`else
      x0 = vt[i].e0; x1 = vt[i].e1; x2 = vt[i].e2;
`endif
      wait_ps();
      measure(-1, 0, h0, h1, h2);
      check($sformatf("vec%0d_ch0_high", i), h0, x0 * CLK_DIV);
      check($sformatf("vec%0d_ch1_high", i), h1, x1 * CLK_DIV);
      check($sformatf("vec%0d_ch2_high", i), h2, x2 * CLK_DIV);
    end

    // Duty change at cnt=7 only takes effect in the next period.
    set_in(1, 0, 5, 15);
    wait_ps();
    measure(7 * CLK_DIV, 10, h0, h1, h2);
    check("midchg_cur_ch1", h1, gam(5) * CLK_DIV);
    wait_ps();
    measure(-1, 0, h0, h1, h2);
    check("midchg_next_ch1", h1, gam(10) * CLK_DIV);

    // Reset mid-period: outputs clear next clk and the period restarts from 0.
    set_in(1, 15, 15, 15);
    wait_ps();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pwm_out", int'(pwm_out), 0);
    check("rst_mid_period_start", int'(period_start), 0);
    check("rst_mid_breath_level", int'(breath_level), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_to_ps(n);
    check("rst_first_period_len", n, PER_CLK);
    check("rst_first_wrap_level", int'(breath_level), 1);

    // BREATHE duty 15: envelope 0..15..0 and high time follows the level.
    rst = 1'b1;
    set_in(2, 15, 15, 15);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 31; j++) begin
      wait_ps();
      check($sformatf("breathe_level_p%0d", j), int'(breath_level), tri_level(j));
      measure(-1, 0, h0, h1, h2);
      check($sformatf("breathe_ch0_p%0d", j), h0, gam((15 * tri_level(j)) >> PW) * CLK_DIV);
      check($sformatf("breathe_ch2_p%0d", j), h2, gam((15 * tri_level(j)) >> PW) * CLK_DIV);
    end

    // BLINK duty 8: on for 15 periods on the way up, off for 15 on the way down.
    rst = 1'b1;
    set_in(3, 8, 8, 8);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 31; j++) begin
      wait_ps();
      measure(-1, 0, h0, h1, h2);
      check($sformatf("blink_ch1_p%0d", j), h1, ((j % 30) < 15) ? gam(8) * CLK_DIV : 0);
    end

    // en drop mid-period, then restart exactly as after reset.
    set_in(1, 15, 8, 0);
    wait_ps();
    repeat (30) @(negedge clk);
    check("en_pre_pwm_out", int'(pwm_out), 1 | ((7 < gam(8)) ? 2 : 0));
    en = 1'b0;
    @(negedge clk);
    check("en_off_pwm_out", int'(pwm_out), 0);
    check("en_off_period_start", int'(period_start), 0);
    check("en_off_breath_level", int'(breath_level), 0);
    repeat (2) @(negedge clk);
    en = 1'b1;
    count_to_ps(n);
    check("en_first_period_len", n, PER_CLK);
    check("en_first_wrap_level", int'(breath_level), 1);
    measure(-1, 0, h0, h1, h2);
    check("en_static8_ch1", h1, gam(8) * CLK_DIV);
    check("en_static15_ch0", h0, PER_CLK);

    // Randomized traffic, checked by the scoreboard every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) duty = (N_CH*PW)'($urandom);
      if (en && $urandom_range(0, 499) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
    end
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
